neuron_cluster: RTL and testbench
=================================

# neuron_cluster

Parametrised successor to the single-lane Ising neuron. It holds NUM_LANES neurons that share one spike stream from the network. Each lane has its own membrane potential, spin, neuron ID, threshold and signed multi-bit coupling row. The block accumulates one network round of spikes through a valid/ready handshake, evaluates all lanes in parallel, and presents one spike code per lane to the network.

## Interface
- NUM_LANES, 4, neurons per cluster
- LANE_ID_WIDTH, 2, log2(NUM_LANES)
- Q_WIDTH, 4, signed two's-complement coupling width
- VMEM_WIDTH, 16, signed membrane potential and threshold width
- NUM_NEURON, 512, coupling entries per lane
- NEURON_ID_WIDTH, 9, neuron/spike ID width
---
- clk  in  1  single clock, rising edge
- reset_l  in  1  reset, asynchronous, active-low
- cfg_we  in  1  config write strobe; honoured only in IDLE
- cfg_sel  in  2  0=Q entry, 1=Vmem, 2=neuron ID, 3=mu
- cfg_lane  in  LANE_ID_WIDTH  target lane
- cfg_addr  in  NEURON_ID_WIDTH  Q row address (cfg_sel=0)
- cfg_data  in  VMEM_WIDTH  write data; low Q_WIDTH / NEURON_ID_WIDTH bits used as applicable
- cfg_ack  out  1  one-cycle pulse, write accepted
- cfg_err  out  1  one-cycle pulse, write rejected
- active_neuron  in  NEURON_ID_WIDTH  count of valid Q rows
- round_start  in  1  one-cycle pulse, begins a round
- spike_valid / spike_ready  in / out  1  spike stream handshake
- spike_in  in  2+NEURON_ID_WIDTH  {code[1:0], id}; code 01=+, 10=−, 00/11=null
- spike_last  in  1  qualifies the final spike of the round
- out_valid / out_ready  out / in  1  result handshake
- spike_out  out  2*NUM_LANES  lane k code at bits [2k+1:2k]
- spin_out  out  NUM_LANES  current spins
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ACCUM, DRAIN, EVAL, EMIT.
- IDLE:
  - cfg_we writes the selected lane field. cfg_ack pulses the next cycle.
  - A Q write with cfg_addr ≥ active_neuron is dropped and pulses cfg_err.
  - cfg_we outside IDLE is dropped and pulses cfg_err.
  - round_start moves to ACCUM. cfg_we in the same cycle takes priority: round_start is ignored.
- ACCUM:
  - spike_ready=1. Each accepted spike reads Q[lane][id] for all lanes (synchronous RAM, registered).
  - Update, one cycle after acceptance:
    - + spike: Vmem += 2·Q.
    - − spike: Vmem −= 2·Q.
    - null spike: no change.
  - 2·Q is sign-extended to VMEM_WIDTH+1 before adding.
  - An id ≥ active_neuron is treated as null.
  - A non-null spike whose id equals a lane's neuron ID flips that lane's spin. Several lanes may share an ID.
  - Accepting a spike with spike_last=1 moves to DRAIN.
- DRAIN: one cycle; the last update lands; spike_ready=0.
- EVAL: for each lane:
  - eff = spin ? Vmem : −Vmem, width VMEM_WIDTH+1.
  - fire = (eff > sign-extended mu), signed compare.
  - code = fire ? (spin ? 2'b10 : 2'b01) : 2'b00.
  - Codes are registered into spike_out.
- EMIT: out_valid=1 and spike_out held stable until out_ready. The handshake returns the block to IDLE; spike_out keeps its value.
- Vmem persists across rounds. Only a cfg write or reset changes it outside ACCUM.
- Reset values: state IDLE; Vmem=0, mu=0, neuron ID=0, spin=all 1; spike_out=0, spin_out=all 1; out_valid, spike_ready, cfg_ack, cfg_err, busy=0. The Q RAM is not reset; contents persist across reset.
- Reset mid-round aborts immediately. The pending pipeline update is discarded.

## Timing
- Spike throughput: 1 per cycle.
- Spike accepted at edge t: Vmem and spin are updated at edge t+1.
- Last spike accepted at edge t: DRAIN at t+1, EVAL at t+2, out_valid high from t+3.
- Minimum round with a single last spike: round_start edge to out_valid = 4 cycles.
- Spin flips take effect in the same round. EVAL uses post-round spin and Vmem.
- spike_valid while spike_ready=0 is not consumed.
- cfg_ack/cfg_err are asserted for exactly the cycle after the cfg_we edge.

## Configuration
- NEURON_SAT_EN defined: Vmem updates saturate at signed VMEM_WIDTH limits (+32767 / −32768 by default).
- NEURON_SAT_EN undefined: Vmem wraps modulo 2^VMEM_WIDTH. No saturation logic is compiled in.

## Test plan
- Config: write Q[1][5]=+3, mu[1]=10, Vmem[1]=8, id[1]=7, active_neuron=16 → four cfg_ack pulses. Q write to addr 20 → cfg_err, RAM unchanged.
- Accumulate: round of {+,5}, {−,5}, {+,5 last} on lane 1 (Q=+3, Vmem=8) → Vmem 14, 8, 14. eff=14>10 with spin 1 → spike_out[3:2]=2'b10; out_valid from 4th cycle after last accept.
- Spin flip: spike {+,7} with id[1]=7 → spin_out[1]=0. Vmem=14 → eff=−14, no fire, code 00. Two lanes with id 7 both flip.
- Saturation: Vmem=32766, Q=+7, + spike → 32767 with NEURON_SAT_EN; −32756 without.
- Backpressure and null: out_ready low 5 cycles → spike_out stable, out_valid held. Code 2'b11 or id≥active_neuron → no Vmem/spin change.
- Reset mid-ACCUM: reset_l low after 2 of 4 spikes → all outputs at reset values, Q RAM retains Q[1][5]=+3.

Source files
------------

// File: rtl/neuron_cluster.sv
// neuron_cluster: NUM_LANES Ising neurons sharing one spike stream.
// Each lane has its own Vmem, spin, neuron ID, threshold mu and signed
// Q coupling row. One network round of spikes is accumulated over a
// valid/ready stream, all lanes are evaluated together, and one 2-bit
// spike code per lane is presented on a valid/ready result port.
// Ports: clk, reset_l (async, active-low);
//   cfg_*  : lane field writes, accepted in IDLE only (ack/err pulse)
//   spike_*: spike stream in, {code, id}, spike_last ends the round
//   out_*  : result handshake, spike_out lane k at [2k+1:2k]
//   spin_out, busy: status
// Build option: NEURON_SAT_EN makes Vmem updates saturate instead of
// wrapping.
`timescale 1ns/1ps
module neuron_cluster #(
  parameter int NUM_LANES       = 4,
  parameter int LANE_ID_WIDTH   = 2,
  parameter int Q_WIDTH         = 4,
  parameter int VMEM_WIDTH      = 16,
  parameter int NUM_NEURON      = 512,
  parameter int NEURON_ID_WIDTH = 9
) (
  input  logic                         clk,
  input  logic                         reset_l,
  input  logic                         cfg_we,
  input  logic [1:0]                   cfg_sel,
  input  logic [LANE_ID_WIDTH-1:0]     cfg_lane,
  input  logic [NEURON_ID_WIDTH-1:0]   cfg_addr,
  input  logic [VMEM_WIDTH-1:0]        cfg_data,
  output logic                         cfg_ack,
  output logic                         cfg_err,
  input  logic [NEURON_ID_WIDTH-1:0]   active_neuron,
  input  logic                         round_start,
  input  logic                         spike_valid,
  output logic                         spike_ready,
  input  logic [NEURON_ID_WIDTH+1:0]   spike_in,
  input  logic                         spike_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*NUM_LANES-1:0]       spike_out,
  output logic [NUM_LANES-1:0]         spin_out,
  output logic                         busy
);

  localparam int VX = VMEM_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_EVAL,
    S_EMIT
  } state_e;

  state_e state_q, state_d;

  logic [VMEM_WIDTH-1:0]      vmem_q [NUM_LANES];
  logic [VMEM_WIDTH-1:0]      vmem_d [NUM_LANES];
  logic [VMEM_WIDTH-1:0]      mu_q   [NUM_LANES];
  logic [VMEM_WIDTH-1:0]      mu_d   [NUM_LANES];
  logic [NEURON_ID_WIDTH-1:0] nid_q  [NUM_LANES];
  logic [NEURON_ID_WIDTH-1:0] nid_d  [NUM_LANES];
  logic [NUM_LANES-1:0]       spin_q, spin_d;
  logic [2*NUM_LANES-1:0]     spk_q, spk_d;
  logic                       ack_q, ack_d;
  logic                       err_q, err_d;

  // Update stage between spike acceptance and the Vmem/spin write.
  logic                       pend_vld_q, pend_vld_d;
  logic                       pend_neg_q, pend_neg_d;
  logic                       pend_last_q, pend_last_d;
  logic [NEURON_ID_WIDTH-1:0] pend_id_q, pend_id_d;

  logic [Q_WIDTH-1:0] q_mem  [NUM_LANES][NUM_NEURON];
  logic [Q_WIDTH-1:0] q_rd_q [NUM_LANES];

  logic [1:0]                 spike_code;
  logic [NEURON_ID_WIDTH-1:0] spike_id;
  logic                       spike_fire;
  logic                       spike_live;
  logic                       cfg_ok;
  logic                       q_we;

  assign spike_code = spike_in[NEURON_ID_WIDTH +: 2];
  assign spike_id   = spike_in[NEURON_ID_WIDTH-1:0];
  assign spike_fire = spike_valid && spike_ready;
  assign spike_live = (spike_code == 2'b01 || spike_code == 2'b10)
                   && (spike_id < active_neuron);

  assign cfg_ok = (cfg_sel != 2'd0) || (cfg_addr < active_neuron);
  assign q_we   = cfg_we && (state_q == S_IDLE)
               && (cfg_sel == 2'd0) && cfg_ok;

  // Once the last spike is taken, the stream closes while its update lands.
  assign spike_ready = (state_q == S_ACCUM) && !pend_last_q;
  assign out_valid   = (state_q == S_EMIT);
  assign busy        = (state_q != S_IDLE);
  assign spike_out   = spk_q;
  assign spin_out    = spin_q;
  assign cfg_ack     = ack_q;
  assign cfg_err     = err_q;

  function automatic logic [VMEM_WIDTH-1:0] acc(
    input logic [VMEM_WIDTH-1:0] v,
    input logic [Q_WIDTH-1:0]    q,
    input logic                  neg
  );
    logic [VX-1:0] dq;
    logic [VX-1:0] sum;
    dq  = {{(VX-Q_WIDTH-1){q[Q_WIDTH-1]}}, q, 1'b0};
    if (neg) dq = -dq;
    sum = {v[VMEM_WIDTH-1], v} + dq;
`ifdef NEURON_SAT_EN
    if (sum[VX-1] != sum[VX-2]) begin
      return sum[VX-1] ? {1'b1, {(VMEM_WIDTH-1){1'b0}}}
                       : {1'b0, {(VMEM_WIDTH-1){1'b1}}};
    end
`endif
    return sum[VMEM_WIDTH-1:0];
  endfunction

  function automatic logic [1:0] eval_code(
    input logic [VMEM_WIDTH-1:0] v,
    input logic [VMEM_WIDTH-1:0] mu,
    input logic                  spin
  );
    logic [VX-1:0] vx;
    logic [VX-1:0] eff;
    logic [VX-1:0] mux;
    vx  = {v[VMEM_WIDTH-1], v};
    eff = spin ? vx : -vx;
    mux = {mu[VMEM_WIDTH-1], mu};
    if ($signed(eff) > $signed(mux)) return spin ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    state_d     = state_q;
    vmem_d      = vmem_q;
    mu_d        = mu_q;
    nid_d       = nid_q;
    spin_d      = spin_q;
    spk_d       = spk_q;
    ack_d       = 1'b0;
    err_d       = cfg_we && (state_q != S_IDLE);
    pend_vld_d  = spike_fire && spike_live;
    pend_neg_d  = (spike_code == 2'b10);
    pend_last_d = spike_fire && spike_last;
    pend_id_d   = spike_id;

    if (pend_vld_q) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        vmem_d[l] = acc(vmem_q[l], q_rd_q[l], pend_neg_q);
        if (pend_id_q == nid_q[l]) spin_d[l] = ~spin_q[l];
      end
    end

    unique case (1'b1)
      state_q == S_IDLE: begin
        if (cfg_we) begin
          ack_d = cfg_ok;
          err_d = !cfg_ok;
          unique case (cfg_sel)
            2'd1: vmem_d[cfg_lane] = cfg_data;
            2'd2: nid_d[cfg_lane]  = cfg_data[NEURON_ID_WIDTH-1:0];
            2'd3: mu_d[cfg_lane]   = cfg_data;
            default: ;
          endcase
        end else if (round_start) begin
          state_d = S_ACCUM;
        end
      end
      state_q == S_ACCUM: begin
        if (pend_last_q) state_d = S_DRAIN;
      end
      state_q == S_DRAIN: begin
        state_d = S_EVAL;
      end
      state_q == S_EVAL: begin
        for (int l = 0; l < NUM_LANES; l++) begin
          spk_d[2*l +: 2] = eval_code(vmem_q[l], mu_q[l], spin_q[l]);
        end
        state_d = S_EMIT;
      end
      state_q == S_EMIT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= S_IDLE;
      spin_q      <= '1;
      spk_q       <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_neg_q  <= 1'b0;
      pend_last_q <= 1'b0;
      pend_id_q   <= '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        vmem_q[l] <= '0;
        mu_q[l]   <= '0;
        nid_q[l]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      vmem_q      <= vmem_d;
      mu_q        <= mu_d;
      nid_q       <= nid_d;
      spin_q      <= spin_d;
      spk_q       <= spk_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      pend_vld_q  <= pend_vld_d;
      pend_neg_q  <= pend_neg_d;
      pend_last_q <= pend_last_d;
      pend_id_q   <= pend_id_d;
    end
  end

  // Coupling RAM: no reset, so contents survive reset_l.
  always_ff @(posedge clk) begin
    if (q_we) q_mem[cfg_lane][cfg_addr] <= cfg_data[Q_WIDTH-1:0];
    if (spike_fire) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        q_rd_q[l] <= q_mem[l][spike_id];
      end
    end
  end

endmodule

// File: tb/tb_neuron_cluster.sv
// tb_neuron_cluster: directed bench for neuron_cluster.
// Expected codes and spins are hand-computed per round.
`timescale 1ns/1ps
module tb_neuron_cluster;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = '0;
  logic [1:0]  cfg_lane = '0;
  logic [8:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        cfg_ack, cfg_err;
  logic [8:0]  active_neuron = 9'd16;
  logic        round_start = 1'b0;
  logic        spike_valid = 1'b0;
  logic        spike_ready;
  logic [10:0] spike_in = '0;
  logic        spike_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  spike_out;
  logic [3:0]  spin_out;
  logic        busy;

  neuron_cluster dut (
    .clk(clk), .reset_l(reset_l),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_lane(cfg_lane),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_ack(cfg_ack), .cfg_err(cfg_err),
    .active_neuron(active_neuron), .round_start(round_start),
    .spike_valid(spike_valid), .spike_ready(spike_ready),
    .spike_in(spike_in), .spike_last(spike_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .spike_out(spike_out), .spin_out(spin_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cfg_wr(input logic [1:0] sel, input logic [1:0] lane,
                        input logic [8:0] addr, input logic [15:0] data,
                        input logic ok);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = sel; cfg_lane = lane;
    cfg_addr = addr; cfg_data = data;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("cfg_ack", cfg_ack, ok);
    check("cfg_err", cfg_err, !ok);
  endtask

  function automatic logic [11:0] sp(input logic last, input logic [1:0] code,
                                     input logic [8:0] id);
    return {last, code, id};
  endfunction

  logic [11:0] sq[$];
  int          lat;
  logic [3:0]  spin_mid;

  task automatic run_round();
    @(negedge clk);
    round_start = 1'b1;
    @(posedge clk); #1;
    round_start = 1'b0;
    foreach (sq[i]) begin
      @(negedge clk);
      check("spike_ready", spike_ready, 1);
      spike_valid = 1'b1;
      {spike_last, spike_in} = sq[i];
      @(posedge clk); #1;
    end
    spike_valid = 1'b0;
    spike_last  = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) spin_mid = spin_out;
      if (out_valid) break;
    end
    check("latency", lat, 3);
  endtask

  task automatic take_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("busy_idle", busy, 0);
  endtask

  logic [7:0] sat_exp;

  initial begin
`ifdef NEURON_SAT_EN
    sat_exp = 8'h00;
`else
    sat_exp = 8'h04;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_spike_out", spike_out, 8'h00);
    check("rst_spin_out", spin_out, 4'hF);
    check("rst_out_valid", out_valid, 0);
    check("rst_spike_ready", spike_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_ack", cfg_ack, 0);
    check("rst_cfg_err", cfg_err, 0);
    @(negedge clk);
    reset_l = 1'b1;

    for (int l = 0; l < 4; l++) begin
      cfg_wr(2'd0, l[1:0], 9'd5, 16'd0, 1'b1);
      cfg_wr(2'd0, l[1:0], 9'd7, 16'd0, 1'b1);
    end
    cfg_wr(2'd0, 2'd1, 9'd5, 16'd3, 1'b1);
    cfg_wr(2'd3, 2'd1, 9'd0, 16'd10, 1'b1);
    cfg_wr(2'd1, 2'd1, 9'd0, 16'd8, 1'b1);
    cfg_wr(2'd2, 2'd1, 9'd0, 16'd7, 1'b1);
    cfg_wr(2'd0, 2'd1, 9'd20, 16'd5, 1'b0);

    // Vmem1 8 -> 14 -> 8 -> 14, eff 14 > 10, spin 1
    sq = '{sp(0, 2'b01, 9'd5), sp(0, 2'b10, 9'd5), sp(1, 2'b01, 9'd5)};
    run_round();
    check("A_spike_out", spike_out, 8'h08);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("A_hold_valid", out_valid, 1);
      check("A_hold_spike", spike_out, 8'h08);
    end
    cfg_wr(2'd1, 2'd1, 9'd0, 16'd0, 1'b0);
    check("A_busy_emit", busy, 1);
    take_out();
    check("A_spike_keep", spike_out, 8'h08);

    // cfg_we beats round_start; also gives lane 2 id 7
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_lane = 2'd2;
    cfg_addr = '0; cfg_data = 16'd7; round_start = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0; round_start = 1'b0;
    check("prio_ack", cfg_ack, 1);
    check("prio_busy", busy, 0);

    // lanes 1 and 2 flip; lane1 eff -14 no fire
    sq = '{sp(1, 2'b01, 9'd7)};
    run_round();
    check("B_spin_mid", spin_mid, 4'b1001);
    check("B_spike_out", spike_out, 8'h00);
    take_out();

    // mu1 = -15: lane1 eff -14 fires 01 while Vmem stays 14
    cfg_wr(2'd3, 2'd1, 9'd0, 16'hFFF1, 1'b1);
    sq = '{sp(0, 2'b11, 9'd5), sp(1, 2'b00, 9'd5)};
    run_round();
    check("C_spin", spin_mid, 4'b1001);
    check("C_spike_out", spike_out, 8'h04);
    take_out();

    active_neuron = 9'd5;
    sq = '{sp(0, 2'b01, 9'd5), sp(1, 2'b01, 9'd7)};
    run_round();
    check("C2_spin", spin_mid, 4'b1001);
    check("C2_spike_out", spike_out, 8'h04);
    take_out();
    active_neuron = 9'd16;

    // 32766 + 14: sat 32767 (eff -32767), wrap -32756 (eff 32756)
    cfg_wr(2'd1, 2'd1, 9'd0, 16'd32766, 1'b1);
    cfg_wr(2'd0, 2'd1, 9'd5, 16'd7, 1'b1);
    sq = '{sp(1, 2'b01, 9'd5)};
    run_round();
    check("D_spike_out", spike_out, {24'd0, sat_exp});
    take_out();

    // reset after 2 of 4 spikes
    cfg_wr(2'd0, 2'd1, 9'd5, 16'd3, 1'b1);
    @(negedge clk);
    round_start = 1'b1;
    @(posedge clk); #1;
    round_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      spike_valid = 1'b1; spike_last = 1'b0;
      spike_in = {2'b01, 9'd5};
      @(posedge clk); #1;
    end
    reset_l = 1'b0;
    spike_valid = 1'b0;
    #1;
    check("E_spike_out", spike_out, 8'h00);
    check("E_spin_out", spin_out, 4'hF);
    check("E_out_valid", out_valid, 0);
    check("E_spike_ready", spike_ready, 0);
    check("E_busy", busy, 0);
    @(negedge clk);
    reset_l = 1'b1;

    // Q[1][5]=3 retained: Vmem 0 -> 6 > mu 0, spin 1
    sq = '{sp(1, 2'b01, 9'd5)};
    run_round();
    check("E_q_kept", spike_out, 8'h08);
    take_out();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
